// File: rtl/pc_sequencer_pkg.sv
// Shared types for the PC sequencer: FSM states, next-PC select codes and the
// priority function that turns commit-time control inputs into a select code.
package pc_sequencer_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

    typedef enum logic [0:0] {
        StFetch = 1'b0,
        StExec  = 1'b1
    } pcu_state_e;

    typedef enum logic [2:0] {
        NpcSeq   = 3'd0,
        NpcBr    = 3'd1,
        NpcJal   = 3'd2,
        NpcJalr  = 3'd3,
        NpcRedir = 3'd4
    } npc_sel_e;

    // Highest priority first; br_taken only matters for B-type instructions.
    function automatic npc_sel_e npc_select(
        input logic redirect_valid,
        input logic is_jalr,
        input logic is_jal,
        input logic is_branch,
        input logic br_taken
    );
        if (redirect_valid) begin
            return NpcRedir;
        end else if (is_jalr) begin
            return NpcJalr;
        end else if (is_jal) begin
            return NpcJal;
        end else if (is_branch && br_taken) begin
            return NpcBr;
        end
        return NpcSeq;
    endfunction

endpackage

// File: rtl/pc_sequencer_npc_target_mux.sv
// Combinational next-PC target mux: select code plus operands to next_pc.
// Any code without its own arm falls back to the sequential pc+4 target.
module pc_sequencer_npc_target_mux
    import pc_sequencer_pkg::*;
(
    input  npc_sel_e    sel,
    input  logic [31:0] pc,
    input  logic [31:0] imm,
    input  logic [31:0] rs1_data,
    input  logic [31:0] redirect_pc,
    output logic [31:0] next_pc
);

    logic [31:0] jalr_sum;
    logic [31:0] rel_target;
    logic [31:0] seq_target;

    assign jalr_sum   = rs1_data + imm;
    assign rel_target = pc + imm;
    assign seq_target = pc + 32'd4;

    always_comb begin
        next_pc = seq_target;
        unique case (sel)
            NpcRedir: next_pc = redirect_pc;
            NpcJalr:  next_pc = jalr_sum & ~32'h1;
            NpcJal:   next_pc = rel_target;
            NpcBr:    next_pc = rel_target;
            default:  next_pc = seq_target;
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// Architectural PC owner: fetch/commit handshake FSM, next-PC selection and retired counter.
// Optional misaligned-target trap is compiled in with `define PCU_MISALIGN_TRAP_EN.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [31:0]      pc,
    output logic             fetch_valid,
    input  logic             fetch_ready,
    input  logic             commit_valid,
    output logic             commit_ready,
    input  logic             is_branch,
    input  logic             br_taken,
    input  logic             is_jal,
    input  logic             is_jalr,
    input  logic [31:0]      imm,
    input  logic [31:0]      rs1_data,
    input  logic             redirect_valid,
    input  logic [31:0]      redirect_pc,
`ifdef PCU_MISALIGN_TRAP_EN
    output logic             misalign_trap,
    output logic [31:0]      misalign_addr,
    input  logic [31:0]      mtvec,
`endif
    output logic [CNT_W-1:0] retired
);

    pcu_state_e       state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    npc_sel_e         npc_sel;
    logic [31:0]      next_pc;
    logic             commit;

    assign npc_sel = npc_select(redirect_valid, is_jalr, is_jal, is_branch, br_taken);

    pc_sequencer_npc_target_mux u_npc_mux (
        .sel         (npc_sel),
        .pc          (pc_q),
        .imm         (imm),
        .rs1_data    (rs1_data),
        .redirect_pc (redirect_pc),
        .next_pc     (next_pc)
    );

    assign commit = (state_q == StExec) && commit_valid;

`ifdef PCU_MISALIGN_TRAP_EN
    logic        trap_q, trap_d;
    logic [31:0] maddr_q, maddr_d;
    logic        misaligned;

    // Redirect targets come from the CSR unit and are trusted as-is.
    assign misaligned = (next_pc[1:0] != 2'b00) && !redirect_valid;
`endif

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        retired_d    = retired_q;
        fetch_valid  = 1'b0;
        commit_ready = 1'b0;
`ifdef PCU_MISALIGN_TRAP_EN
        trap_d       = 1'b0;
        maddr_d      = maddr_q;
`endif
        unique case (state_q)
            StFetch: begin
                fetch_valid = 1'b1;
                if (fetch_ready) begin
                    state_d = StExec;
                end
            end
            StExec: begin
                commit_ready = 1'b1;
                if (commit) begin
                    state_d = StFetch;
`ifdef PCU_MISALIGN_TRAP_EN
                    if (misaligned) begin
                        pc_d    = mtvec;
                        trap_d  = 1'b1;
                        maddr_d = next_pc;
                    end else begin
                        pc_d      = next_pc;
                        retired_d = retired_q + CNT_W'(1);
                    end
`else
                    pc_d      = next_pc;
                    retired_d = retired_q + CNT_W'(1);
`endif
                end
            end
            default: state_d = StFetch;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StFetch;
            pc_q      <= RESET_PC;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            retired_q <= retired_d;
        end
    end

`ifdef PCU_MISALIGN_TRAP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trap_q  <= 1'b0;
            maddr_q <= '0;
        end else begin
            trap_q  <= trap_d;
            maddr_q <= maddr_d;
        end
    end

    assign misalign_trap = trap_q;
    assign misalign_addr = maddr_q;
`endif

    assign pc      = pc_q;
    assign retired = retired_q;

endmodule
